// File: rtl/param_sync_ram.sv
// param_sync_ram: single-port synchronous RAM whose init sequencer fills every word with INIT_VAL after reset
module param_sync_ram #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 3,
  parameter int                RD_MODE  = 0,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  output logic              busy
);
  typedef enum logic {INIT, READY} state_t;
  state_t            r_state;
  logic [ADDR_W-1:0] r_init_cnt;
  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic              w_acc;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_din;
  assign w_acc      = r_state == READY && req;
  assign w_mem_we   = r_state == INIT || (w_acc && we);
  assign w_mem_addr = r_state == INIT ? r_init_cnt : addr;
  assign w_mem_din  = r_state == INIT ? INIT_VAL : data_in;
  always_ff @(posedge clk)
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state    <= INIT;
      r_init_cnt <= '0;
      out        <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b1;
    end else if (r_state == INIT) begin
      out_valid <= 1'b0;
      if (r_init_cnt == '1) begin
        r_state <= READY;
        busy    <= 1'b0;
      end else
        r_init_cnt <= r_init_cnt + 1'b1;
    end else begin
      out_valid <= req;
      if (req) out <= (we && RD_MODE == 1) ? data_in : r_mem[addr];
    end
endmodule
